// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and helpers for the LC-3 register-file write side.
//   word_t    : DATA_W-bit result / register value
//   reg_idx_t : architectural register index
//   cnt_t     : per-register outstanding-write counter
//   cc_t      : packed {n, z, p} condition codes
//   cc_from() : condition codes implied by a result word
package lc3_pkg;

   localparam int DATA_W  = 16;
   localparam int REG_N   = 8;
   localparam int REG_AW  = $clog2(REG_N);
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (2 ** CNT_W) - 1;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [REG_AW-1:0] reg_idx_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   typedef struct packed {
      logic n;
      logic z;
      logic p;
   } cc_t;

   localparam cc_t CC_RESET = '{n: 1'b0, z: 1'b1, p: 1'b0};

   // Exactly one of n/z/p is set for any input word.
   function automatic cc_t cc_from(input word_t data);
      cc_t cc;
      cc.n = data[DATA_W-1];
      cc.z = (data == '0);
      cc.p = ~cc.n & ~cc.z;
      return cc;
   endfunction

endpackage : lc3_pkg

// File: rtl/lc3_scoreboard.sv
// lc3_scoreboard: per-register pending-write counters used by decode to stall
// on RAW hazards.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_issue_valid/dr   : decode reserves destination register i_issue_dr
//   o_issue_ready      : 0 while in reset or when the counter for i_issue_dr is full
//   i_ret_en/dr        : register file write this cycle (retires one reservation)
//   o_pending[i]       : register i has at least one outstanding write
//   o_sb_err           : sticky; a write retired to a register with no reservation
module lc3_scoreboard
   import lc3_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_issue_valid,
   input  reg_idx_t         i_issue_dr,
   output logic             o_issue_ready,
   input  logic             i_ret_en,
   input  reg_idx_t         i_ret_dr,
   output logic [REG_N-1:0] o_pending,
   output logic             o_sb_err
);

   localparam cnt_t CNT_SAT = cnt_t'(CNT_MAX);

   cnt_t             r_cnt [REG_N];
   logic             r_sb_err;
   logic             w_issue_fire;
   logic [REG_N-1:0] w_inc;
   logic [REG_N-1:0] w_dec;
   logic [REG_N-1:0] w_underflow;

   // A full counter refuses further reservations instead of wrapping.
   assign o_issue_ready = ~i_rst & (r_cnt[i_issue_dr] != CNT_SAT);
   assign w_issue_fire  = i_issue_valid & o_issue_ready;
   assign o_sb_err      = r_sb_err;

   always_comb begin
      for (int i = 0; i < REG_N; i++) begin
         w_inc[i]       = w_issue_fire & (i_issue_dr == reg_idx_t'(i));
         w_dec[i]       = i_ret_en & (i_ret_dr == reg_idx_t'(i));
         // A simultaneous reservation cancels the retire, so only a lone retire can underflow.
         w_underflow[i] = w_dec[i] & ~w_inc[i] & (r_cnt[i] == '0);
         o_pending[i]   = (r_cnt[i] != '0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // NOTE: this counter array is explicitly reset: pending must read 0 after
         // reset, so unlike a data RAM it cannot come up with arbitrary contents.
         for (int i = 0; i < REG_N; i++) begin
            r_cnt[i] <= '0;
         end
         r_sb_err <= 1'b0;
      end else begin
         for (int i = 0; i < REG_N; i++) begin
            if (w_inc[i] & ~w_dec[i]) begin
               r_cnt[i] <= r_cnt[i] + cnt_t'(1);
            end else if (w_dec[i] & ~w_inc[i] & (r_cnt[i] != '0)) begin
               r_cnt[i] <= r_cnt[i] - cnt_t'(1);
            end
         end
         if (|w_underflow) begin
            r_sb_err <= 1'b1;
         end
      end
   end

endmodule : lc3_scoreboard

// File: rtl/lc3_writeback.sv
// lc3_writeback: merges memory-load and ALU results onto the single register
// file write port, maintains N/Z/P, and hosts the RAW-hazard scoreboard.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_issue_valid/dr, o_issue_ready : destination reservation from decode
//   i_mem_valid/dr/data/setcc, o_mem_ready : load result (highest priority)
//   i_alu_valid/dr/data/setcc, o_alu_ready : ALU/LEA result
//   o_rf_en/dr/data              : registered register-file write port
//   o_cc_n/z/p                   : registered condition codes
//   o_pending                    : per-register outstanding-write flags
//   o_sb_err                     : sticky scoreboard underflow flag
module lc3_writeback
   import lc3_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_issue_valid,
   input  logic [REG_AW-1:0] i_issue_dr,
   output logic              o_issue_ready,
   input  logic              i_mem_valid,
   output logic              o_mem_ready,
   input  logic [REG_AW-1:0] i_mem_dr,
   input  logic [DATA_W-1:0] i_mem_data,
   input  logic              i_mem_setcc,
   input  logic              i_alu_valid,
   output logic              o_alu_ready,
   input  logic [REG_AW-1:0] i_alu_dr,
   input  logic [DATA_W-1:0] i_alu_data,
   input  logic              i_alu_setcc,
   output logic              o_rf_en,
   output logic [REG_AW-1:0] o_rf_dr,
   output logic [DATA_W-1:0] o_rf_data,
   output logic              o_cc_n,
   output logic              o_cc_z,
   output logic              o_cc_p,
   output logic [REG_N-1:0]  o_pending,
   output logic              o_sb_err
);

   logic     r_rf_en;
   reg_idx_t r_rf_dr;
   word_t    r_rf_data;
   cc_t      r_cc;

   logic     w_mem_xfer;
   logic     w_alu_xfer;
   logic     w_xfer;
   reg_idx_t w_sel_dr;
   word_t    w_sel_data;
   logic     w_sel_setcc;

   // Memory always wins; the ALU is held off whenever a load is offered.
   assign o_mem_ready = ~i_rst;
   assign o_alu_ready = ~i_rst & ~i_mem_valid;
   assign w_mem_xfer  = i_mem_valid & o_mem_ready;
   assign w_alu_xfer  = i_alu_valid & o_alu_ready;
   assign w_xfer      = w_mem_xfer | w_alu_xfer;

   always_comb begin
      // NOTE: every output gets a default before the branch so no path leaves it
      // unassigned; otherwise synthesis infers a latch to hold the old value.
      w_sel_dr    = i_alu_dr;
      w_sel_data  = i_alu_data;
      w_sel_setcc = i_alu_setcc;
      if (w_mem_xfer) begin
         w_sel_dr    = i_mem_dr;
         w_sel_data  = i_mem_data;
         w_sel_setcc = i_mem_setcc;
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would let later lines see updated state.
      if (i_rst) begin
         r_rf_en   <= 1'b0;
         r_rf_dr   <= '0;
         r_rf_data <= '0;
         r_cc      <= CC_RESET;
      end else begin
         r_rf_en <= w_xfer;
         // dr/data hold their last values when nothing transfers.
         if (w_xfer) begin
            r_rf_dr   <= w_sel_dr;
            r_rf_data <= w_sel_data;
            if (w_sel_setcc) begin
               r_cc <= cc_from(w_sel_data);
            end
         end
      end
   end

   assign o_rf_en   = r_rf_en;
   assign o_rf_dr   = r_rf_dr;
   assign o_rf_data = r_rf_data;
   assign o_cc_n    = r_cc.n;
   assign o_cc_z    = r_cc.z;
   assign o_cc_p    = r_cc.p;

   // Retire on the registered write port: the register file captures at the
   // same edge, so pending clears exactly when the new value becomes readable.
   lc3_scoreboard u_scoreboard (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_issue_valid (i_issue_valid),
      .i_issue_dr    (i_issue_dr),
      .o_issue_ready (o_issue_ready),
      .i_ret_en      (r_rf_en),
      .i_ret_dr      (r_rf_dr),
      .o_pending     (o_pending),
      .o_sb_err      (o_sb_err)
   );

endmodule : lc3_writeback

// File: tb/tb_lc3_writeback.sv
// tb_lc3_writeback: directed stimulus for lc3_writeback. A transaction-level
// model (outstanding-write counts, last write, condition codes) is compared
// with the DUT every falling edge; hand-computed literals pin key points.
module tb_lc3_writeback;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic [2:0]  issue_dr;
   logic        issue_ready;
   logic        mem_valid;
   logic        mem_ready;
   logic [2:0]  mem_dr;
   logic [15:0] mem_data;
   logic        mem_setcc;
   logic        alu_valid;
   logic        alu_ready;
   logic [2:0]  alu_dr;
   logic [15:0] alu_data;
   logic        alu_setcc;
   logic        rf_en;
   logic [2:0]  rf_dr;
   logic [15:0] rf_data;
   logic        cc_n;
   logic        cc_z;
   logic        cc_p;
   logic [7:0]  pending;
   logic        sb_err;

   int n_checks = 0;
   int n_err    = 0;

   lc3_writeback dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_issue_valid (issue_valid),
      .i_issue_dr    (issue_dr),
      .o_issue_ready (issue_ready),
      .i_mem_valid   (mem_valid),
      .o_mem_ready   (mem_ready),
      .i_mem_dr      (mem_dr),
      .i_mem_data    (mem_data),
      .i_mem_setcc   (mem_setcc),
      .i_alu_valid   (alu_valid),
      .o_alu_ready   (alu_ready),
      .i_alu_dr      (alu_dr),
      .i_alu_data    (alu_data),
      .i_alu_setcc   (alu_setcc),
      .o_rf_en       (rf_en),
      .o_rf_dr       (rf_dr),
      .o_rf_data     (rf_data),
      .o_cc_n        (cc_n),
      .o_cc_z        (cc_z),
      .o_cc_p        (cc_p),
      .o_pending     (pending),
      .o_sb_err      (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_cnt [8];
   logic        m_en;
   logic [2:0]  m_dr;
   logic [15:0] m_data;
   logic [2:0]  m_cc;      // {n,z,p}
   logic        m_err;
   bit          chk_on = 0;
   bit          mx, ax, ix;
   int          delta;

   function automatic logic [2:0] cc_of(input logic [15:0] d);
      if (d == 16'h0000)  return 3'b010;
      else if (d >= 16'h8000) return 3'b100;
      else                return 3'b001;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) m_cnt[i] = 0;
         m_en   = 1'b0;
         m_dr   = 3'd0;
         m_data = 16'h0000;
         m_cc   = 3'b010;
         m_err  = 1'b0;
         chk_on = 1;
      end else if (chk_on) begin
         mx = mem_valid;
         ax = alu_valid && !mem_valid;
         ix = issue_valid && (m_cnt[issue_dr] < 3);
         for (int i = 0; i < 8; i++) begin
            delta = 0;
            if (ix && issue_dr == i) delta = delta + 1;
            if (m_en && m_dr == i)   delta = delta - 1;
            if (delta < 0 && m_cnt[i] == 0) m_err = 1'b1;
            else m_cnt[i] = m_cnt[i] + delta;
         end
         m_en = mx || ax;
         if (mx) begin
            m_dr = mem_dr; m_data = mem_data;
            if (mem_setcc) m_cc = cc_of(mem_data);
         end else if (ax) begin
            m_dr = alu_dr; m_data = alu_data;
            if (alu_setcc) m_cc = cc_of(alu_data);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [7:0] exp_pend;
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 8; i++) exp_pend[i] = (m_cnt[i] != 0);
         check("m_rf_en",   32'(rf_en),   32'(m_en));
         check("m_rf_dr",   32'(rf_dr),   32'(m_dr));
         check("m_rf_data", 32'(rf_data), 32'(m_data));
         check("m_cc",      32'({cc_n, cc_z, cc_p}), 32'(m_cc));
         check("m_pending", 32'(pending), 32'(exp_pend));
         check("m_sb_err",  32'(sb_err),  32'(m_err));
         check("m_issue_ready", 32'(issue_ready), 32'(!rst && m_cnt[issue_dr] != 3));
         check("m_mem_ready",   32'(mem_ready),   32'(!rst));
         check("m_alu_ready",   32'(alu_ready),   32'(!rst && !mem_valid));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      mem_valid   = 1'b0;
      alu_valid   = 1'b0;
   endtask

   task automatic alu(input logic [2:0] dr, input logic [15:0] d, input logic sc);
      alu_valid = 1'b1; alu_dr = dr; alu_data = d; alu_setcc = sc;
   endtask

   task automatic mem(input logic [2:0] dr, input logic [15:0] d, input logic sc);
      mem_valid = 1'b1; mem_dr = dr; mem_data = d; mem_setcc = sc;
   endtask

   task automatic issue(input logic [2:0] dr);
      issue_valid = 1'b1; issue_dr = dr;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      issue_dr = 3'd0; mem_dr = 3'd0; mem_data = 16'h0; mem_setcc = 1'b0;
      alu_dr = 3'd0; alu_data = 16'h0; alu_setcc = 1'b0;

      // Reset: offers during reset must be refused and dropped.
      step();
      issue(3'd0); mem(3'd1, 16'h1111, 1'b1); alu(3'd2, 16'h2222, 1'b1);
      #1;
      check("rst_mem_ready",   32'(mem_ready),   32'h0);
      check("rst_alu_ready",   32'(alu_ready),   32'h0);
      check("rst_issue_ready", 32'(issue_ready), 32'h0);
      step();
      rst = 1'b0; idle();
      check("rst_rf_en",   32'(rf_en),   32'h0);
      check("rst_cc",      32'({cc_n, cc_z, cc_p}), 32'b010);
      check("rst_pending", 32'(pending), 32'h00);
      check("rst_sb_err",  32'(sb_err),  32'h0);
      step();

      // ALU write to R3 with setcc.
      issue(3'd3); step();
      check("alu_pend_set", 32'(pending), 32'h08);
      idle(); alu(3'd3, 16'h8001, 1'b1); step();
      check("alu_rf_en",   32'(rf_en),   32'h1);
      check("alu_rf_dr",   32'(rf_dr),   32'h3);
      check("alu_rf_data", 32'(rf_data), 32'h8001);
      check("alu_cc",      32'({cc_n, cc_z, cc_p}), 32'b100);
      check("alu_pend_hold", 32'(pending), 32'h08);
      idle(); step();
      check("alu_rf_en_off", 32'(rf_en),   32'h0);
      check("alu_pend_clr",  32'(pending), 32'h00);
      check("alu_data_hold", 32'(rf_data), 32'h8001);

      // Contention: memory beats ALU, back-to-back writes.
      issue(3'd1); step();
      issue(3'd2); step();
      idle(); mem(3'd1, 16'h0000, 1'b1); alu(3'd2, 16'h0005, 1'b1);
      #1;
      check("cont_alu_ready", 32'(alu_ready), 32'h0);
      check("cont_mem_ready", 32'(mem_ready), 32'h1);
      step();
      check("cont1_rf_dr", 32'(rf_dr),   32'h1);
      check("cont1_data",  32'(rf_data), 32'h0000);
      check("cont1_cc",    32'({cc_n, cc_z, cc_p}), 32'b010);
      mem_valid = 1'b0; step();
      check("cont2_rf_en", 32'(rf_en),   32'h1);
      check("cont2_rf_dr", 32'(rf_dr),   32'h2);
      check("cont2_data",  32'(rf_data), 32'h0005);
      check("cont2_cc",    32'({cc_n, cc_z, cc_p}), 32'b001);
      idle(); step();
      check("cont_rf_en_off", 32'(rf_en),   32'h0);
      check("cont_pend",      32'(pending), 32'h00);
      check("cont_sb_err",    32'(sb_err),  32'h0);

      // Overlap on R5: issue in the retire cycle holds the count.
      issue(3'd5); step(); step();
      check("ovl_pend2", 32'(pending), 32'h20);
      idle(); alu(3'd5, 16'h0042, 1'b0); step();
      idle(); issue(3'd5);
      #1;
      check("ovl_ready_at2", 32'(issue_ready), 32'h1);
      step();
      check("ovl_ready_hold", 32'(issue_ready), 32'h1);
      step();
      check("ovl_ready_sat", 32'(issue_ready), 32'h0);
      step();
      check("ovl_ready_sat2", 32'(issue_ready), 32'h0);
      idle();
      alu(3'd5, 16'h0001, 1'b0); step();
      check("b2b1_en", 32'(rf_en), 32'h1);
      alu(3'd5, 16'h0002, 1'b0); step();
      check("b2b2_en", 32'(rf_en), 32'h1);
      alu(3'd5, 16'h0003, 1'b0); step();
      check("b2b3_en", 32'(rf_en), 32'h1);
      check("b2b3_data", 32'(rf_data), 32'h0003);
      idle(); step();
      check("ovl_pend_clr", 32'(pending), 32'h00);
      check("ovl_sb_err",   32'(sb_err),  32'h0);
      check("ovl_cc_keep",  32'({cc_n, cc_z, cc_p}), 32'b001);

      // Underflow: unreserved write to R7 still lands, flags the scoreboard.
      alu(3'd7, 16'h1234, 1'b0); step();
      check("unf_rf_dr",   32'(rf_dr),   32'h7);
      check("unf_rf_data", 32'(rf_data), 32'h1234);
      idle(); step();
      check("unf_sb_err", 32'(sb_err), 32'h1);
      step(); step();
      check("unf_sb_sticky", 32'(sb_err),  32'h1);
      check("unf_pend",      32'(pending), 32'h00);

      // Reset mid-stream: the in-flight retire and a concurrent offer are dropped.
      issue(3'd4); step();
      idle(); alu(3'd4, 16'hFFFF, 1'b1); step();
      check("mid_rf_en",   32'(rf_en),   32'h1);
      check("mid_cc",      32'({cc_n, cc_z, cc_p}), 32'b100);
      check("mid_pending", 32'(pending), 32'h10);
      idle(); rst = 1'b1; mem(3'd6, 16'h0777, 1'b1); step();
      check("mid_rst_rf_en", 32'(rf_en),   32'h0);
      check("mid_rst_cc",    32'({cc_n, cc_z, cc_p}), 32'b010);
      check("mid_rst_pend",  32'(pending), 32'h00);
      check("mid_rst_err",   32'(sb_err),  32'h0);
      check("mid_rst_data",  32'(rf_data), 32'h0000);
      rst = 1'b0; idle(); step();
      check("mid_after_en", 32'(rf_en), 32'h0);
      step(); step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_lc3_writeback
